// File: rtl/fpu_issue_ctrl.sv
// FP issue/writeback controller: 3-stage pipe tag tracking, iterative
// div/sqrt FSM, RAW/WAW/structural stall logic and write-port arbitration.
module fpu_issue_ctrl #(
    parameter int DIV_CYCLES = 24
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       id_valid,
    input  logic       id_fadd,
    input  logic       id_fsub,
    input  logic       id_fmul,
    input  logic       id_fdiv,
    input  logic       id_fsqrt,
    input  logic [4:0] id_fs,
    input  logic [4:0] id_ft,
    input  logic [4:0] id_fd,
    output logic       stall,
    output logic       pipe_en,
    output logic [1:0] pipe_op,
    output logic       div_start,
    output logic       div_op,
    output logic       wb_we,
    output logic       wb_sel,
    output logic [4:0] wb_fd,
    output logic       busy
);

    localparam int CW = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        D_IDLE,
        D_BUSY,
        D_WB
    } dstate_t;

    dstate_t         dstate;
    logic [CW-1:0]   cnt;
    logic [4:0]      dfd;
    logic            e1_v, e2_v, e3_v;
    logic [4:0]      e1_fd, e2_fd, e3_fd;

    logic any_op, pipe_req, div_req, chk_ft;
    logic raw_pipe, div_haz, struct_haz, issue;

    assign any_op   = id_fadd | id_fsub | id_fmul | id_fdiv | id_fsqrt;
    assign pipe_req = id_fadd | id_fsub | id_fmul;
    assign div_req  = id_fdiv | id_fsqrt;
    assign chk_ft   = ~id_fsqrt;

    // E3 is excluded: the write-through register file forwards it
    assign raw_pipe =
        (e1_v && (e1_fd == id_fs || (chk_ft && e1_fd == id_ft))) ||
        (e2_v && (e2_fd == id_fs || (chk_ft && e2_fd == id_ft)));

    assign div_haz = (dstate != D_IDLE) &&
        (dfd == id_fs || (chk_ft && dfd == id_ft) || dfd == id_fd);

    assign struct_haz = div_req && (dstate != D_IDLE);

    // gated by clrn so nothing leaks out while reset is held
    assign stall = clrn & id_valid & any_op &
                   (raw_pipe | div_haz | struct_haz);
    assign issue   = clrn & id_valid & any_op & ~stall;
    assign pipe_en = issue & pipe_req;

    always_comb begin
        pipe_op = 2'b00;
        if (pipe_en) begin
            unique case (1'b1)
                id_fmul: pipe_op = 2'b10;
                id_fsub: pipe_op = 2'b01;
                default: pipe_op = 2'b00;
            endcase
        end
    end

    always_comb begin
        wb_we  = 1'b0;
        wb_sel = 1'b0;
        wb_fd  = 5'd0;
        if (e3_v) begin
            wb_we = 1'b1;
            wb_fd = e3_fd;
        end else if (dstate == D_WB) begin
            wb_we  = 1'b1;
            wb_sel = 1'b1;
            wb_fd  = dfd;
        end
    end

    assign busy = e1_v | e2_v | e3_v | (dstate != D_IDLE);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            e1_v      <= 1'b0;
            e2_v      <= 1'b0;
            e3_v      <= 1'b0;
            e1_fd     <= 5'd0;
            e2_fd     <= 5'd0;
            e3_fd     <= 5'd0;
            dstate    <= D_IDLE;
            cnt       <= '0;
            dfd       <= 5'd0;
            div_op    <= 1'b0;
            div_start <= 1'b0;
        end else begin
            e1_v      <= pipe_en;
            e1_fd     <= id_fd;
            e2_v      <= e1_v;
            e2_fd     <= e1_fd;
            e3_v      <= e2_v;
            e3_fd     <= e2_fd;
            div_start <= 1'b0;
            unique case (dstate)
                D_IDLE: begin
                    if (issue && div_req) begin
                        dstate    <= D_BUSY;
                        cnt       <= CW'(DIV_CYCLES - 1);
                        dfd       <= id_fd;
                        div_op    <= id_fsqrt;
                        div_start <= 1'b1;
                    end
                end
                D_BUSY: begin
                    if (cnt == '0)
                        dstate <= D_WB;
                    else
                        cnt <= cnt - 1'b1;
                end
                D_WB: begin
                    if (!e3_v)
                        dstate <= D_IDLE;
                end
                default: dstate <= D_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: cycle-stamped issue/writeback model checked
// every cycle, plus directed scenarios with literal timing expectations.
module tb_fpu_issue_ctrl;

    localparam int DIV = 24;

    logic       clk = 1'b0;
    logic       clrn;
    logic       id_valid;
    logic       id_fadd, id_fsub, id_fmul, id_fdiv, id_fsqrt;
    logic [4:0] id_fs, id_ft, id_fd;
    logic       stall, pipe_en, div_start, div_op;
    logic       wb_we, wb_sel, busy;
    logic [1:0] pipe_op;
    logic [4:0] wb_fd;

    fpu_issue_ctrl #(.DIV_CYCLES(DIV)) dut (
        .clk(clk), .clrn(clrn), .id_valid(id_valid),
        .id_fadd(id_fadd), .id_fsub(id_fsub), .id_fmul(id_fmul),
        .id_fdiv(id_fdiv), .id_fsqrt(id_fsqrt),
        .id_fs(id_fs), .id_ft(id_ft), .id_fd(id_fd),
        .stall(stall), .pipe_en(pipe_en), .pipe_op(pipe_op),
        .div_start(div_start), .div_op(div_op),
        .wb_we(wb_we), .wb_sel(wb_sel), .wb_fd(wb_fd), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 8;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d",
                     nm, cyc, act, exp);
        end
    endtask

    // model: pipe issues stamped by cycle, divider as one pending job
    logic       pv [4];
    logic [4:0] pfd [4];
    logic       d_pend;
    int         d_t;
    logic [4:0] d_fd;
    logic       d_op;
    logic       m_issue;

    logic       lg_we [1024];
    logic       lg_sel [1024];
    logic [4:0] lg_fd [1024];
    logic       lg_ds [1024];

    logic       x_stall, x_pen, x_ds, x_dop, x_we, x_sel, x_busy;
    logic [1:0] x_op;
    logic [4:0] x_fd;
    logic       any, preq, dreq, haz, p3, d_wr;

    always @(negedge clk) begin
        x_stall = 0; x_pen = 0; x_op = 0; x_ds = 0; x_dop = 0;
        x_we = 0; x_sel = 0; x_fd = 0; x_busy = 0; m_issue = 0;
        d_wr = 0;
        if (!clrn) begin
            for (int k = 0; k < 4; k++) begin
                pv[k] = 0;
                pfd[k] = 0;
            end
            d_pend = 0;
            d_op = 0;
            d_t = 0;
            d_fd = 0;
        end else begin
            any  = id_fadd | id_fsub | id_fmul | id_fdiv | id_fsqrt;
            preq = id_fadd | id_fsub | id_fmul;
            dreq = id_fdiv | id_fsqrt;
            haz = 0;
            for (int k = 1; k <= 2; k++) begin
                if (pv[(cyc - k) & 3] &&
                    (pfd[(cyc - k) & 3] == id_fs ||
                     (!id_fsqrt && pfd[(cyc - k) & 3] == id_ft)))
                    haz = 1;
            end
            if (d_pend && (d_fd == id_fs || d_fd == id_fd ||
                           (!id_fsqrt && d_fd == id_ft)))
                haz = 1;
            if (dreq && d_pend)
                haz = 1;
            x_stall = id_valid && any && haz;
            m_issue = id_valid && any && !haz;
            x_pen = m_issue && preq;
            if (x_pen)
                x_op = id_fmul ? 2'd2 : (id_fsub ? 2'd1 : 2'd0);
            p3 = pv[(cyc - 3) & 3];
            d_wr = d_pend && !p3 && (cyc >= d_t + DIV + 1);
            x_ds = d_pend && (cyc == d_t + 1);
            x_dop = d_op;
            if (p3) begin
                x_we = 1;
                x_fd = pfd[(cyc - 3) & 3];
            end else if (d_wr) begin
                x_we = 1;
                x_sel = 1;
                x_fd = d_fd;
            end
            x_busy = pv[(cyc - 1) & 3] | pv[(cyc - 2) & 3] | p3 | d_pend;
        end
        chk("stall", stall, x_stall);
        chk("pipe_en", pipe_en, x_pen);
        chk("pipe_op", pipe_op, x_op);
        chk("div_start", div_start, x_ds);
        chk("div_op", div_op, x_dop);
        chk("wb_we", wb_we, x_we);
        chk("wb_sel", wb_sel, x_sel);
        chk("wb_fd", wb_fd, x_fd);
        chk("busy", busy, x_busy);
        if (clrn) begin
            if (d_wr)
                d_pend = 0;
            if (m_issue && dreq) begin
                d_pend = 1;
                d_t = cyc;
                d_fd = id_fd;
                d_op = id_fsqrt;
            end
            pv[cyc & 3] = x_pen;
            pfd[cyc & 3] = id_fd;
        end
        if (cyc < 1024) begin
            lg_we[cyc] = wb_we;
            lg_sel[cyc] = wb_sel;
            lg_fd[cyc] = wb_fd;
            lg_ds[cyc] = div_start;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_valid = 0;
        id_fadd = 0; id_fsub = 0; id_fmul = 0; id_fdiv = 0; id_fsqrt = 0;
        id_fs = 0; id_ft = 0; id_fd = 0;
    endtask

    task automatic set_in(input int op, input int fd, input int fs,
                          input int ft);
        id_valid = 1;
        id_fadd = (op == 0); id_fsub = (op == 1); id_fmul = (op == 2);
        id_fdiv = (op == 3); id_fsqrt = (op == 4);
        id_fd = 5'(fd); id_fs = 5'(fs); id_ft = 5'(ft);
    endtask

    task automatic idle(input int n);
        clr_in();
        repeat (n) tick();
    endtask

    // hold the instruction until the model says it issues
    task automatic present(input int op, input int fd, input int fs,
                           input int ft, output int t, output int ns);
        bit done;
        set_in(op, fd, fs, ft);
        ns = 0;
        t = -1;
        done = 0;
        while (!done) begin
            @(negedge clk);
            #1;
            if (m_issue) begin
                t = cyc - 1;
                done = 1;
            end else begin
                ns++;
                if (ns > 200) begin
                    checks++;
                    fails++;
                    $display("FAIL issue_timeout cyc=%0d", cyc);
                    done = 1;
                end else begin
                    tick();
                end
            end
        end
        tick();
        clr_in();
    endtask

    int t1, t2, t3, n1, n2, n3;
    bit found;

    initial begin
        clrn = 0;
        clr_in();
        for (int i = 0; i < 5; i++) begin
            id_valid = 1'($urandom);
            set_in($urandom_range(0, 4), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 31));
            id_valid = 1'($urandom);
            @(negedge clk);
            #1;
            chk("rst_outs",
                {stall, pipe_en, pipe_op, div_start, div_op,
                 wb_we, wb_sel, wb_fd, busy}, 0);
            tick();
        end
        clr_in();
        clrn = 1;
        idle(2);

        // independent fadd then fmul
        present(0, 1, 2, 3, t1, n1);
        present(2, 4, 5, 6, t2, n2);
        chk("indep_fadd_nostall", n1, 0);
        chk("indep_fmul_nostall", n2, 0);
        chk("indep_fmul_t", t2, t1 + 1);
        idle(6);
        chk("indep_wb1", {lg_we[t1+3], lg_sel[t1+3], lg_fd[t1+3]},
            {1'b1, 1'b0, 5'd1});
        chk("indep_wb2", {lg_we[t1+4], lg_sel[t1+4], lg_fd[t1+4]},
            {1'b1, 1'b0, 5'd4});

        // RAW through E1/E2
        present(0, 1, 2, 3, t1, n1);
        present(1, 7, 1, 2, t2, n2);
        chk("raw_stalls", n2, 2);
        chk("raw_issue_t", t2, t1 + 3);
        idle(6);
        chk("raw_wb", {lg_we[t2+3], lg_fd[t2+3]}, {1'b1, 5'd7});

        // divider structural hazard
        present(3, 5, 1, 2, t1, n1);
        present(3, 6, 3, 4, t2, n2);
        chk("div_start_t1", lg_ds[t1+1], 1);
        chk("div_f6_stalls", n2, 25);
        chk("div_f6_issue", t2, t1 + 26);
        idle(30);
        chk("div_wb_f5", {lg_we[t1+25], lg_sel[t1+25], lg_fd[t1+25]},
            {1'b1, 1'b1, 5'd5});
        chk("div_wb_f6", {lg_we[t1+51], lg_sel[t1+51], lg_fd[t1+51]},
            {1'b1, 1'b1, 5'd6});

        // write-port conflict between pipe and divider
        present(3, 5, 1, 2, t1, n1);
        idle(21);
        present(0, 9, 10, 11, t2, n2);
        present(2, 12, 5, 13, t3, n3);
        idle(8);
        chk("conf_fadd_t", t2, t1 + 22);
        chk("conf_pipe_wb", {lg_we[t1+25], lg_sel[t1+25], lg_fd[t1+25]},
            {1'b1, 1'b0, 5'd9});
        chk("conf_div_wb", {lg_we[t1+26], lg_sel[t1+26], lg_fd[t1+26]},
            {1'b1, 1'b1, 5'd5});
        chk("conf_fmul_stalls", n3, 4);
        chk("conf_fmul_t", t3, t1 + 27);

        // reset while the divider is busy
        present(3, 5, 1, 2, t1, n1);
        idle(9);
        clrn = 0;
        @(negedge clk);
        #1;
        chk("midrst_outs",
            {stall, pipe_en, div_start, div_op, wb_we, busy}, 0);
        tick();
        tick();
        clrn = 1;
        idle(30);
        found = 0;
        for (int c = t1; c < cyc && c < 1024; c++)
            if (lg_we[c] && lg_sel[c] && lg_fd[c] == 5'd5)
                found = 1;
        chk("midrst_no_f5", found, 0);
        present(4, 8, 1, 2, t2, n2);
        chk("midrst_new_div", n2, 0);
        idle(30);
        chk("sqrt_wb", {lg_we[t2+25], lg_sel[t2+25], lg_fd[t2+25]},
            {1'b1, 1'b1, 5'd8});

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
